// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port unified memory between the instruction-fetch (IF)
//   and load/store (DM) stages of a pipelined MIPS core. One requester is
//   granted at a time; the memory request is held until mem_ack (or until the
//   access times out), after which read data and a one-cycle done pulse go
//   back to the winner. The stall lines freeze the core while an access is
//   outstanding.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   if_req/if_addr        fetch request (held until if_done) and address
//   if_rdata/if_done      fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_addr  data request (held until dm_done), store flag, address
//   dm_wdata              store data
//   dm_rdata/dm_done      load data and one-cycle completion pulse
//   mem_req/mem_we        memory request and write enable (registered)
//   mem_addr/mem_wdata    memory address and write data (registered at grant)
//   mem_rdata/mem_ack     memory read data and one-cycle completion
//   if_stall/dm_stall     combinational stall lines to the pipeline
//   err                   one-cycle pulse with done when an access timed out
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              err
);

  localparam logic [3:0] MAX_S    = 4'(MAX_STREAK);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t     state;
  logic [3:0] streak;
  logic [7:0] tcnt;

  logic if_live;
  logic dm_live;
  logic grant_if;
  logic grant_dm;
  logic finish;

  // Streak counter saturates at the anti-starvation limit.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == MAX_S) ? v : v + 4'd1;
  endfunction

  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  // A requester whose done pulse is high this cycle still shows req=1 but is
  // about to drop it, so it must not win a fresh grant.
  assign if_live = if_req & ~if_done;
  assign dm_live = dm_req & ~dm_done;

  always_comb begin
    grant_dm = dm_live & (~if_live | (streak != MAX_S));
    grant_if = if_live & ~grant_dm;
  end

  // An access ends on mem_ack, or on the last permitted cycle without one;
  // an ack arriving in that last cycle still counts as a real completion.
  assign finish = mem_ack | (tcnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_done   <= 1'b0;
      dm_done   <= 1'b0;
      err       <= 1'b0;
      streak    <= '0;
      tcnt      <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            state     <= BUSY_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            tcnt      <= '0;
            streak    <= if_req ? sat_inc(streak) : 4'd0;
          end else if (grant_if) begin
            state     <= BUSY_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            tcnt      <= '0;
            streak    <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (finish) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            err     <= ~mem_ack;
            if (state == BUSY_IF) begin
              if_done  <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end else begin
              dm_done <= 1'b1;
              // Stores leave the load-data register untouched.
              if (!mem_we) dm_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
